// File: rtl/bp_common_pkg.sv
// Shared stall-trace encodings: record codes, the retire code and reader FSM states.
package bp_common_pkg;

  localparam int bp_reason_width_gp = 5;

  typedef enum logic [bp_reason_width_gp-1:0] {
    e_ifetch_miss       = 5'd0,
    e_icache_fill       = 5'd1,
    e_itlb_miss         = 5'd2,
    e_branch_mispredict = 5'd3,
    e_control_haz       = 5'd4,
    e_long_haz          = 5'd5,
    e_data_haz          = 5'd6,
    e_aux_dep           = 5'd7,
    e_load_dep          = 5'd8,
    e_mul_dep           = 5'd9,
    e_fma_dep           = 5'd10,
    e_sb_iraw_dep       = 5'd11,
    e_sb_fraw_dep       = 5'd12,
    e_sb_iwaw_dep       = 5'd13,
    e_sb_fwaw_dep       = 5'd14,
    e_struct_haz        = 5'd15,
    e_idiv_haz          = 5'd16,
    e_fdiv_haz          = 5'd17,
    e_ptw_busy          = 5'd18,
    e_special           = 5'd19,
    e_replay            = 5'd20,
    e_exception         = 5'd21,
    e_cmd_fence         = 5'd22,
    e_dtlb_miss         = 5'd23
  } bp_stall_reason_e;

  // Record code meaning "instruction retired" rather than a stall
  localparam logic [bp_reason_width_gp-1:0] bp_retire_code_gp = 5'd24;

  typedef enum logic [1:0] {
    e_idle,
    e_clear,
    e_dump
  } bp_stall_fsm_e;

endpackage

// File: rtl/bp_stall_hist_counters.sv
// Bank of saturating histogram counters with synchronous clear and one indexed read port.
module bp_stall_hist_counters
  import bp_common_pkg::*;
#(
  parameter int num_p   = 25,
  parameter int width_p = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_li,
  input  logic                          clear_i,
  input  logic                          inc_v_i,
  input  logic [bp_reason_width_gp-1:0] inc_idx_i,
  input  logic [bp_reason_width_gp-1:0] rd_idx_i,
  output logic [width_p-1:0]            rd_data_o
);

  localparam logic [bp_reason_width_gp:0] num_lp = (bp_reason_width_gp+1)'(num_p);

  logic [width_p-1:0] cnt_r [num_p];

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      for (int i = 0; i < num_p; i++) cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < num_p; i++) begin
        if (clear_i)
          cnt_r[i] <= '0;
        else if (inc_v_i && (inc_idx_i == bp_reason_width_gp'(i)) && !(&cnt_r[i]))
          cnt_r[i] <= cnt_r[i] + width_p'(1);
      end
    end
  end

  assign rd_data_o = ({1'b0, rd_idx_i} < num_lp) ? cnt_r[rd_idx_i] : '0;

endmodule

// File: rtl/bp_stall_trace_reader.sv
// Histograms per-cycle stall/retire trace records, tracks the longest stall run,
// and serializes the histogram out on request through a valid/ready beat stream.
module bp_stall_trace_reader
  import bp_common_pkg::*;
#(
  parameter int num_reasons_p = 25,
  parameter int cnt_width_p   = 32,
  parameter int run_width_p   = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_li,
  input  logic                          rec_v_i,
  input  logic [bp_reason_width_gp-1:0] rec_reason_i,
  output logic                          rec_ready_o,
  input  logic                          clear_i,
  input  logic                          dump_i,
  output logic                          busy_o,
  output logic                          out_v_o,
  input  logic                          out_ready_i,
  output logic [bp_reason_width_gp-1:0] out_idx_o,
  output logic [cnt_width_p-1:0]        out_count_o,
  output logic                          out_last_o,
  output logic [run_width_p-1:0]        max_run_o,
  output logic                          err_o
);

  localparam logic [bp_reason_width_gp:0]   num_lp      = (bp_reason_width_gp+1)'(num_reasons_p);
  localparam logic [bp_reason_width_gp-1:0] last_idx_lp = bp_reason_width_gp'(num_reasons_p-1);

  bp_stall_fsm_e                 state_r, state_n;
  logic [bp_reason_width_gp-1:0] idx_r, inc_idx;
  logic [run_width_p-1:0]        cur_run_r, run_inc;
  logic                          err_r;
  logic                          rec_acc, code_ok, is_retire, beat_acc, is_last;

  assign rec_ready_o = (state_r == e_idle) && !clear_i && !dump_i;
  assign rec_acc     = rec_v_i && rec_ready_o;
  assign code_ok     = {1'b0, rec_reason_i} < num_lp;
  // Out-of-range codes are folded onto bin 0 and flagged
  assign inc_idx     = code_ok ? rec_reason_i : '0;
  assign is_retire   = (rec_reason_i == bp_retire_code_gp);
  assign run_inc     = (&cur_run_r) ? cur_run_r : cur_run_r + run_width_p'(1);

  assign out_v_o     = (state_r == e_dump);
  assign is_last     = (idx_r == last_idx_lp);
  assign out_last_o  = out_v_o && is_last;
  assign beat_acc    = out_v_o && out_ready_i;
  assign busy_o      = (state_r != e_idle);
  assign out_idx_o   = idx_r;
  assign err_o       = err_r;

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_idle:  if (clear_i) state_n = e_clear;
               else if (dump_i) state_n = e_dump;
      e_clear: state_n = e_idle;
      e_dump:  if (beat_acc && is_last) state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) state_r <= e_idle;
    else           state_r <= state_n;
  end

  // idx parks at 0 outside DUMP so every dump starts from bin 0
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li)                idx_r <= '0;
    else if (state_r != e_dump)   idx_r <= '0;
    else if (beat_acc)            idx_r <= is_last ? '0 : idx_r + bp_reason_width_gp'(1);
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      cur_run_r <= '0;
      max_run_o <= '0;
      err_r     <= 1'b0;
    end else if (state_r == e_clear) begin
      cur_run_r <= '0;
      max_run_o <= '0;
      err_r     <= 1'b0;
    end else if (rec_acc) begin
      if (is_retire) begin
        cur_run_r <= '0;
      end else begin
        cur_run_r <= run_inc;
        if (run_inc > max_run_o) max_run_o <= run_inc;
      end
      if (!code_ok) err_r <= 1'b1;
    end
  end

  bp_stall_hist_counters #(
    .num_p   (num_reasons_p),
    .width_p (cnt_width_p)
  ) u_hist (
    .clk_i     (clk_i),
    .reset_li  (reset_li),
    .clear_i   (state_r == e_clear),
    .inc_v_i   (rec_acc),
    .inc_idx_i (inc_idx),
    .rd_idx_i  (idx_r),
    .rd_data_o (out_count_o)
  );

endmodule

// File: doc/bp_stall_trace_reader.md
BP_STALL_TRACE_READER -- requirements
Module: bp_stall_trace_reader

Interface
REQ-001 Parameter num_reasons_p, default 25, number of record codes (0..23 stall reasons, 24 = instruction retired).
REQ-002 Parameter cnt_width_p, default 32, width of each histogram counter.
REQ-003 Parameter run_width_p, default 16, width of the run-length registers.
REQ-004 clk_i  in  1  clock; all state updates on posedge.
REQ-005 reset_li  in  1  reset, asynchronous, active-low.
REQ-006 rec_v_i  in  1  per-cycle trace record valid.
REQ-007 rec_reason_i  in  5  record code, encoded as bp_stall_reason_e, with 24 = retire.
REQ-008 rec_ready_o  out  1  record accepted when rec_v_i & rec_ready_o.
REQ-009 clear_i  in  1  request to zero all statistics.
REQ-010 dump_i  in  1  request to serialize all counters out.
REQ-011 busy_o  out  1  FSM not in IDLE.
REQ-012 out_v_o  out  1  dump beat valid.
REQ-013 out_ready_i  in  1  dump beat accepted.
REQ-014 out_idx_o  out  5  code index of the current beat.
REQ-015 out_count_o  out  cnt_width_p  counter value for out_idx_o.
REQ-016 out_last_o  out  1  final beat (index num_reasons_p-1).
REQ-017 max_run_o  out  run_width_p  longest run of consecutive accepted non-retire records.
REQ-018 err_o  out  1  sticky flag: a record with code >= num_reasons_p was accepted.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR and DUMP.
REQ-020 rec_ready_o SHALL be 1 only in IDLE with clear_i=0 and dump_i=0.
REQ-021 Each accepted record SHALL increment counter[code] at the next posedge, saturating at 2^cnt_width_p-1.
REQ-022 An accepted code >= num_reasons_p SHALL increment counter[0] instead and set err_o.
REQ-023 Run-length tracking on each accepted record:
- non-retire: cur_run increments, saturating.
- retire (24): cur_run is cleared.
- max_run_o SHALL be updated to max(max_run_o, cur_run+1) in the same cycle as a non-retire acceptance.
REQ-024 IDLE with clear_i=1 SHALL transition to CLEAR; CLEAR SHALL zero all counters, cur_run, max_run_o and err_o in one cycle, then return to IDLE.
REQ-025 IDLE with dump_i=1 and clear_i=0 SHALL transition to DUMP with idx=0; clear_i has priority over dump_i.
REQ-026 In DUMP, out_v_o SHALL be 1 and out_count_o SHALL equal counter[idx] combinationally.
REQ-027 On each out_v_o & out_ready_i, idx SHALL increment; on the beat with idx = num_reasons_p-1, out_last_o=1 and the FSM SHALL return to IDLE at that posedge.
REQ-028 While out_ready_i=0 in DUMP, out_idx_o and out_count_o SHALL hold stable.
REQ-029 A dump SHALL take exactly num_reasons_p handshakes; dump_i and clear_i SHALL be ignored outside IDLE.
REQ-030 Counters SHALL not change during DUMP, since rec_ready_o=0.

Reset
REQ-031 Asserting reset_li, including mid-dump, SHALL immediately force:
- FSM to IDLE and idx=0;
- all counters, cur_run, max_run_o and err_o to 0;
- out_v_o=0, out_last_o=0 and busy_o=0.
REQ-032 rec_ready_o SHALL be 1 on the first cycle after reset deassertion, provided no request is pending.

Structure
REQ-033 bp_stall_reason_e, the retire code constant (24) and the FSM state enum SHALL live in bp_common_pkg.
REQ-034 The counter array SHALL be one sub-module, bp_stall_hist_counters, providing saturating increment, clear, and an indexed read port.

Verification
REQ-035 Accept 10 records of code 6 and then 1 retire; dump -> beat 6 = 10, beat 24 = 1, all others 0, max_run_o = 10.
REQ-036 Dump with out_ready_i toggling 1/0 every cycle -> 25 beats in order, index and count stable while stalled, out_last_o only on index 24, rec_ready_o=0 throughout the dump.
REQ-037 Preload counter[3] to 2^32-2 and accept 3 records of code 3 -> dumped value is 2^32-1.
REQ-038 Accept code 30 -> counter[0] increments and err_o=1; clear_i and dump_i asserted together -> CLEAR takes priority, then all zero and err_o=0.
REQ-039 Assert reset_li at dump beat 5 -> outputs zero immediately; after release a new dump starts at index 0 with all counts 0.
